tdm_mux: RTL and testbench

Parametrised, registered N-channel multiplexer with an active-low enable, manual select mode and an automatic round-robin scan mode with per-channel dwell time. It is the next-generation replacement for the combinational 4:1 enable mux. It feeds serialised channel data to downstream logic with a one-cycle `valid` strobe, a channel tag and a frame marker.

---
 rtl/tdm_mux.sv | 180 ++++++++++++++++++
 tb/tb_tdm_mux.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_mux.sv
// Registered N-channel TDM multiplexer: manual select or round-robin scan with per-channel dwell.
// Optional build macro TDM_MUX_SKIP_MASK_EN adds a per-channel skip mask for scan mode.
module tdm_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      e,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          s,
    input  logic [CHANNELS*WIDTH-1:0] i,
`ifdef TDM_MUX_SKIP_MASK_EN
    input  logic [CHANNELS-1:0]       skip,
`endif
    output logic [WIDTH-1:0]          y,
    output logic [SEL_W-1:0]          ch,
    output logic                      valid,
    output logic                      frame
);

    localparam int DCNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DWELL - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] MANUAL = 2'd1;
    localparam logic [1:0] SCAN   = 2'd2;

    logic [1:0]        state, state_d;
    logic [SEL_W-1:0]  ptr, ptr_d;
    logic [DCNT_W-1:0] dcnt, dcnt_d;
    logic [WIDTH-1:0]  y_d;
    logic [SEL_W-1:0]  ch_d;
    logic              valid_d, frame_d;

    logic [CHANNELS-1:0] mask;
    logic [WIDTH-1:0]    chan [CHANNELS];

`ifdef TDM_MUX_SKIP_MASK_EN
    assign mask = skip;
`else
    assign mask = '0;
`endif

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        assign chan[k] = i[k*WIDTH +: WIDTH];
    end

    // Next unmasked channel strictly after 'from', wrapping; returns 'from' if none.
    function automatic logic [SEL_W-1:0] next_unmasked(input logic [SEL_W-1:0] from,
                                                       input logic [CHANNELS-1:0] m);
        logic [SEL_W-1:0] r;
        logic             found;
        int               idx;
        r     = from;
        found = 1'b0;
        for (int k = 1; k <= CHANNELS; k++) begin
            idx = (int'(from) + k) % CHANNELS;
            if (!found && !m[idx]) begin
                r     = SEL_W'(idx);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [SEL_W-1:0] first_unmasked(input logic [CHANNELS-1:0] m);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (!m[k]) r = SEL_W'(k);
        end
        return r;
    endfunction

    function automatic logic [SEL_W-1:0] last_unmasked(input logic [CHANNELS-1:0] m);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!m[k]) r = SEL_W'(k);
        end
        return r;
    endfunction

    logic              s_in_range;
    logic              all_masked;
    logic [SEL_W-1:0]  first_unm, last_unm;
    logic [SEL_W-1:0]  scan_ptr, cur;
    logic [DCNT_W-1:0] scan_dcnt;

    assign s_in_range = int'(s) < CHANNELS;
    assign all_masked = &mask;
    assign first_unm  = first_unmasked(mask);
    assign last_unm   = last_unmasked(mask);

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
        state_d   = state;
        ptr_d     = ptr;
        dcnt_d    = dcnt;
        y_d       = y;
        ch_d      = ch;
        valid_d   = 1'b0;
        frame_d   = 1'b0;
        scan_ptr  = ptr;
        scan_dcnt = dcnt;
        cur       = ptr;

        if (e) begin
            state_d = IDLE;
            y_d     = '0;
            ch_d    = '0;
            ptr_d   = '0;
            dcnt_d  = '0;
        end else if (!mode) begin
            state_d = MANUAL;
            ch_d    = s;
            ptr_d   = '0;
            dcnt_d  = '0;
            if (s_in_range) begin
                y_d     = chan[s];
                valid_d = 1'b1;
            end else begin
                y_d = '0;
            end
        end else begin
            state_d = SCAN;
            // Any entry into scan, including a return from manual, restarts the round.
            if (state != SCAN) begin
                scan_ptr  = first_unm;
                scan_dcnt = '0;
            end

            if (all_masked) begin
                ptr_d  = ptr;
                dcnt_d = '0;
            end else begin
                // A channel masked while dwelling is abandoned for the next live one.
                cur = mask[scan_ptr] ? next_unmasked(scan_ptr, mask) : scan_ptr;
                if (cur != scan_ptr) scan_dcnt = '0;

                if (scan_dcnt == DCNT_LAST) begin
                    y_d     = chan[cur];
                    ch_d    = cur;
                    valid_d = 1'b1;
                    frame_d = (cur == last_unm);
                    dcnt_d  = '0;
                    ptr_d   = next_unmasked(cur, mask);
                end else begin
                    dcnt_d = scan_dcnt + 1'b1;
                    ptr_d  = cur;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            dcnt  <= '0;
            y     <= '0;
            ch    <= '0;
            valid <= 1'b0;
            frame <= 1'b0;
        end else begin
            state <= state_d;
            ptr   <= ptr_d;
            dcnt  <= dcnt_d;
            y     <= y_d;
            ch    <= ch_d;
            valid <= valid_d;
            frame <= frame_d;
        end
    end

endmodule

// File: tb/tb_tdm_mux.sv
// Self-checking bench for tdm_mux: manual vector table, scan/dwell/reset sequences and random traffic.
// Three instances: 4ch dwell 1, 3ch dwell 1 (out-of-range select), 4ch dwell 3.
module tb_tdm_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic        e_in, mode_in;
    logic [1:0]  s_in;
    logic [31:0] i_in;
    logic [3:0]  skip_in;

    logic [7:0] y0, y1, y2;
    logic [1:0] ch0, ch1, ch2;
    logic       v0, v1, v2, f0, f1, f2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tdm_mux #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .DWELL(1)) u4 (
        .clk(clk), .rst(rst), .e(e_in), .mode(mode_in), .s(s_in), .i(i_in),
`ifdef TDM_MUX_SKIP_MASK_EN
        .skip(skip_in),
`endif
        .y(y0), .ch(ch0), .valid(v0), .frame(f0));

    tdm_mux #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .DWELL(1)) u3 (
        .clk(clk), .rst(rst), .e(e_in), .mode(mode_in), .s(s_in), .i(i_in[23:0]),
`ifdef TDM_MUX_SKIP_MASK_EN
        .skip(3'b000),
`endif
        .y(y1), .ch(ch1), .valid(v1), .frame(f1));

    tdm_mux #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .DWELL(3)) ud3 (
        .clk(clk), .rst(rst), .e(e_in), .mode(mode_in), .s(s_in), .i(i_in),
`ifdef TDM_MUX_SKIP_MASK_EN
        .skip(4'b0000),
`endif
        .y(y2), .ch(ch2), .valid(v2), .frame(f2));

    // Reference model: scan outputs are derived from the edge count since scan entry.
    int         mc[3] = '{4, 3, 4};
    int         md[3] = '{1, 1, 3};
    logic [7:0] my[3];
    logic [1:0] mch[3];
    logic       mv[3], mf[3];
    bit         mscan[3];
    int         mn[3];

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            my[d] = '0; mch[d] = '0; mv[d] = 1'b0; mf[d] = 1'b0; mscan[d] = 1'b0; mn[d] = 0;
        end
    endtask

    task automatic model_edge();
        int lst[$];
        int idx, k;
        for (int d = 0; d < 3; d++) begin
            if (e_in) begin
                my[d] = '0; mch[d] = '0; mv[d] = 1'b0; mf[d] = 1'b0; mscan[d] = 1'b0;
            end else if (!mode_in) begin
                mch[d] = s_in; mf[d] = 1'b0; mscan[d] = 1'b0;
                if (int'(s_in) < mc[d]) begin
                    my[d] = i_in[int'(s_in)*8 +: 8]; mv[d] = 1'b1;
                end else begin
                    my[d] = '0; mv[d] = 1'b0;
                end
            end else begin
                if (!mscan[d]) mn[d] = 0;
                mscan[d] = 1'b1;
                mn[d]++;
                lst.delete();
                for (int c = 0; c < mc[d]; c++)
                    if (!(d == 0 && skip_in[c])) lst.push_back(c);
                mv[d] = 1'b0; mf[d] = 1'b0;
                if (lst.size() > 0 && mn[d] % md[d] == 0) begin
                    idx    = (mn[d] / md[d] - 1) % lst.size();
                    k      = lst[idx];
                    my[d]  = i_in[k*8 +: 8];
                    mch[d] = 2'(k);
                    mv[d]  = 1'b1;
                    mf[d]  = (k == lst[lst.size()-1]);
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input int d, input logic [7:0] yy, input logic [1:0] cc,
                       input logic vv, input logic ff);
        check($sformatf("m%0d_y", d), 32'(yy), 32'(my[d]));
        check($sformatf("m%0d_ch", d), 32'(cc), 32'(mch[d]));
        check($sformatf("m%0d_valid", d), 32'(vv), 32'(mv[d]));
        check($sformatf("m%0d_frame", d), 32'(ff), 32'(mf[d]));
    endtask

    // One clock edge: update model with current inputs, then compare all instances.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cmp(0, y0, ch0, v0, f0);
        cmp(1, y1, ch1, v1, f1);
        cmp(2, y2, ch2, v2, f2);
    endtask

    task automatic drive(input logic e, input logic m);
        e_in = e; mode_in = m;
    endtask

    typedef struct {
        logic        e;
        logic [1:0]  s;
        logic [31:0] i;
        logic [7:0]  y4;
        logic        v4;
        logic [7:0]  y3;
        logic        v3;
    } vec_t;

    vec_t vecs[6];
    logic [7:0] seq4[4];

    initial begin
        rst = 1'b1; e_in = 1'b1; mode_in = 1'b0; s_in = '0; i_in = '0; skip_in = '0;
        model_reset();
        #1;
        check("reset_y", 32'(y0), 0);
        check("reset_ch", 32'(ch0), 0);
        check("reset_valid", 32'(v0), 0);
        check("reset_frame", 32'(f0), 0);
        #12 rst = 1'b0;

        // Manual mode vectors: ch is 0 when disabled, s otherwise.
        vecs[0] = '{1'b0, 2'd2, 32'h44332211, 8'h33, 1'b1, 8'h33, 1'b1};
        vecs[1] = '{1'b0, 2'd0, 32'h44332211, 8'h11, 1'b1, 8'h11, 1'b1};
        vecs[2] = '{1'b0, 2'd3, 32'h44332211, 8'h44, 1'b1, 8'h00, 1'b0};
        vecs[3] = '{1'b1, 2'd2, 32'h44332211, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{1'b0, 2'd1, 32'hdeadbeef, 8'hbe, 1'b1, 8'hbe, 1'b1};
        vecs[5] = '{1'b0, 2'd3, 32'ha5a5c3c3, 8'ha5, 1'b1, 8'h00, 1'b0};
        for (int n = 0; n < 6; n++) begin
            drive(vecs[n].e, 1'b0);
            s_in = vecs[n].s; i_in = vecs[n].i;
            step();
            check($sformatf("vec%0d_y4", n), 32'(y0), 32'(vecs[n].y4));
            check($sformatf("vec%0d_v4", n), 32'(v0), 32'(vecs[n].v4));
            check($sformatf("vec%0d_ch4", n), 32'(ch0), vecs[n].e ? 0 : 32'(vecs[n].s));
            check($sformatf("vec%0d_y3", n), 32'(y1), 32'(vecs[n].y3));
            check($sformatf("vec%0d_v3", n), 32'(v1), 32'(vecs[n].v3));
            check($sformatf("vec%0d_ch3", n), 32'(ch1), vecs[n].e ? 0 : 32'(vecs[n].s));
        end

        // Scan with DWELL=1: 11,22,33,44 repeating, frame with 44.
        seq4 = '{8'h11, 8'h22, 8'h33, 8'h44};
        i_in = 32'h44332211;
        drive(1'b0, 1'b1);
        for (int n = 0; n < 8; n++) begin
            step();
            check($sformatf("scan1_y%0d", n), 32'(y0), 32'(seq4[n % 4]));
            check($sformatf("scan1_frame%0d", n), 32'(f0), (n % 4 == 3) ? 1 : 0);
        end

        // Scan with DWELL=3: samples on edges 3,6,9,12 after entry.
        drive(1'b1, 1'b1); step();
        drive(1'b0, 1'b1);
        for (int n = 1; n <= 12; n++) begin
            step();
            check($sformatf("dwell3_valid%0d", n), 32'(v2), (n % 3 == 0) ? 1 : 0);
            if (n % 3 == 0) check($sformatf("dwell3_ch%0d", n), 32'(ch2), 32'(n / 3 - 1));
        end

        // Manual at edge 7 mid-scan, then back: next sample is ch 0 three edges later.
        drive(1'b1, 1'b1); step();
        drive(1'b0, 1'b1);
        for (int n = 1; n <= 6; n++) step();
        drive(1'b0, 1'b0); s_in = 2'd2; step();
        drive(1'b0, 1'b1);
        step(); check("resume_valid8", 32'(v2), 0);
        step(); check("resume_valid9", 32'(v2), 0);
        step(); check("resume_valid10", 32'(v2), 1);
        check("resume_ch10", 32'(ch2), 0);

        // Asynchronous reset mid-scan.
        for (int n = 0; n < 2; n++) step();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("arst_y", 32'(y0), 0);
        check("arst_ch", 32'(ch0), 0);
        check("arst_valid", 32'(v0), 0);
        check("arst_frame", 32'(f0), 0);
        check("arst_y_d3", 32'(y2), 0);
        #2 rst = 1'b0;
        step();
        check("arst_restart_ch", 32'(ch0), 0);
        check("arst_restart_y", 32'(y0), 32'h11);
        check("arst_restart_valid", 32'(v0), 1);

`ifdef TDM_MUX_SKIP_MASK_EN
        drive(1'b1, 1'b1); skip_in = 4'b0101; step();
        drive(1'b0, 1'b1);
        for (int n = 0; n < 6; n++) begin
            step();
            check($sformatf("skip_ch%0d", n), 32'(ch0), (n % 2 == 0) ? 1 : 3);
            check($sformatf("skip_frame%0d", n), 32'(f0), (n % 2 == 1) ? 1 : 0);
        end
        drive(1'b1, 1'b1); skip_in = 4'b1111; step();
        drive(1'b0, 1'b1);
        for (int n = 0; n < 4; n++) begin
            step();
            check($sformatf("skipall_valid%0d", n), 32'(v0), 0);
        end
        skip_in = 4'b0000;
`endif

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            e_in    = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) mode_in = ~mode_in;
            s_in    = 2'($urandom_range(0, 3));
            i_in    = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
